mem_port_arbiter: RTL and testbench

Arbitrates one shared single-ported memory between the core's instruction-fetch port and its data port (MEM stage). It replaces the separate insmem/datamem instances when both are backed by one unified memory. Each transaction runs as a valid/ready handshake with a variable-latency response, and at most one transaction is outstanding. Data accesses win over fetches, and a starvation counter bounds how long fetch can be locked out. A fetch flush, raised on a taken branch or jump, discards the fetch response still in flight.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : fetch/data arbiter in front of one single-ported memory
// Rev 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [2:0]        m_size,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic       OWN_I      = 1'b0;
  localparam logic       OWN_D      = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  logic [1:0]        state_q,   state_d;
  logic              owner_q,   owner_d;
  logic              drop_q,    drop_d;
  logic [3:0]        starve_q,  starve_d;
  logic              m_we_q,    m_we_d;
  logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [2:0]        m_size_q,  m_size_d;

  logic idle;
  logic starved;
  logic resp;

  // Grants are combinational and only ever raised in IDLE.
  always_comb begin
    idle    = (state_q == ST_IDLE);
    starved = i_req && (starve_q == STARVE_LIM);
    d_gnt   = idle && d_req && !starved;
    i_gnt   = idle && i_req && !d_gnt;
    resp    = (state_q == ST_WAIT) && m_rvalid;
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = 4'd0;
    end else if (d_gnt && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_d    = drop_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_size_d  = m_size_q;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (d_gnt) begin
          state_d   = ST_ISSUE;
          owner_d   = OWN_D;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_size_d  = d_size;
        end else if (i_gnt) begin
          state_d   = ST_ISSUE;
          owner_d   = OWN_I;
          drop_d    = i_flush;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          m_size_d  = SIZE_WORD;
        end
      end
      ST_ISSUE: begin
        if ((owner_q == OWN_I) && i_flush) begin
          drop_d = 1'b1;
        end
        if (m_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if ((owner_q == OWN_I) && i_flush) begin
          drop_d = 1'b1;
        end
        if (m_rvalid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // A flush in the response cycle itself also discards the fetch data.
  always_comb begin
    m_req    = (state_q == ST_ISSUE);
    m_we     = m_we_q;
    m_addr   = m_addr_q;
    m_wdata  = m_wdata_q;
    m_size   = m_size_q;
    i_rvalid = resp && (owner_q == OWN_I) && !drop_q && !i_flush;
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rvalid = resp && (owner_q == OWN_D);
    d_rdata  = (d_rvalid && !m_we_q) ? m_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      drop_q    <= 1'b0;
      starve_q  <= 4'd0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= 3'b000;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      drop_q    <= drop_d;
      starve_q  <= starve_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q  <= m_size_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench with a variable-latency memory model
// Rev 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_size;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_size;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        is_i;
  } req_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  req_t        req_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  bit          busy = 0, busy_is_i = 0, cur_dropped = 0;
  bit          slave_en = 0, rand_mode = 0;
  int          rd_cfg = 0, rv_cfg = 1;
  string       glog = "";
  int          n_irv = 0, n_drv = 0;
  logic [31:0] last_i_rdata = 0, last_d_rdata = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant tracker: records grants and pushes the expected responses.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (i_gnt || d_gnt) chk("gnt_exclusive", {31'b0, i_gnt & d_gnt}, 32'd0);
        if (d_gnt) begin
          glog = {glog, "D"};
          req_q.push_back('{we: d_we, addr: d_addr, wdata: d_wdata, size: d_size, is_i: 1'b0});
          if (d_we) begin
            ref_mem[d_addr] = d_wdata;
            exp_d.push_back(32'd0);
          end else begin
            exp_d.push_back(ref_rd(d_addr));
          end
          busy = 1; busy_is_i = 0;
        end else if (i_gnt) begin
          glog = {glog, "I"};
          req_q.push_back('{we: 1'b0, addr: i_addr, wdata: 32'd0, size: 3'b010, is_i: 1'b1});
          busy = 1; busy_is_i = 1; cur_dropped = i_flush;
          if (!i_flush) exp_i.push_back(ref_rd(i_addr));
        end
        if (m_rvalid && slave_en) busy = 0;
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk); #2;
      if (i_rvalid) begin
        n_irv++; last_i_rdata = i_rdata;
        if (exp_i.size() == 0) chk("i_rvalid_unexpected", {31'b0, i_rvalid}, 32'd0);
        else chk("i_rdata", i_rdata, exp_i.pop_front());
      end else if (m_rvalid) begin
        chk("i_rdata_quiet", i_rdata, 32'd0);
      end
      if (d_rvalid) begin
        n_drv++; last_d_rdata = d_rdata;
        if (exp_d.size() == 0) chk("d_rvalid_unexpected", {31'b0, d_rvalid}, 32'd0);
        else chk("d_rdata", d_rdata, exp_d.pop_front());
      end else if (m_rvalid) begin
        chk("d_rdata_quiet", d_rdata, 32'd0);
      end
    end
  end

  // Memory model: checks request fields, holds them through stalls, responds.
  initial begin
    req_t        r;
    int          rd, rv;
    logic [31:0] a;
    m_ready = 0; m_rvalid = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (slave_en && !rst && m_req) begin
        rd = rand_mode ? int'($urandom_range(0, 5)) : rd_cfg;
        rv = rand_mode ? int'($urandom_range(1, 8)) : rv_cfg;
        r  = '0;
        if (req_q.size() == 0) chk("m_req_unexpected", {31'b0, m_req}, 32'd0);
        else r = req_q.pop_front();
        chk("m_addr", m_addr, r.addr);
        chk("m_we", {31'b0, m_we}, {31'b0, r.we});
        chk("m_size", {29'b0, m_size}, {29'b0, r.size});
        if (!r.is_i) chk("m_wdata", m_wdata, r.wdata);
        for (int k = 0; k < rd; k++) begin
          @(negedge clk);
          chk("hold_m_req", {31'b0, m_req}, 32'd1);
          chk("hold_m_addr", m_addr, r.addr);
          chk("hold_m_we", {31'b0, m_we}, {31'b0, r.we});
          if (!r.is_i) chk("hold_m_wdata", m_wdata, r.wdata);
        end
        m_ready = 1;
        a = m_addr;
        if (m_we) slv_mem[a] = m_wdata;
        @(negedge clk);
        m_ready = 0;
        for (int k = 1; k < rv; k++) @(negedge clk);
        m_rvalid = 1;
        m_rdata  = r.we ? 32'hFFFF_FFFF : slv_rd(a);
        @(negedge clk);
        m_rvalid = 0;
        m_rdata  = 0;
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    int n = 0;
    @(posedge clk); #1;
    i_req = 1; i_addr = a;
    do begin @(negedge clk); #3; n++; end while (!i_gnt && n < 300);
    if (!i_gnt) chk("i_gnt_timeout", {31'b0, i_gnt}, 32'd1);
    @(posedge clk); #1;
    i_req = 0;
  endtask

  task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] sz);
    int n = 0;
    @(posedge clk); #1;
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_size = sz;
    do begin @(negedge clk); #3; n++; end while (!d_gnt && n < 300);
    if (!d_gnt) chk("d_gnt_timeout", {31'b0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    d_req = 0;
  endtask

  // Drives a one-cycle flush; retires the pending fetch expectation if one is in flight.
  task automatic pulse_flush();
    i_flush = 1;
    if (busy && busy_is_i && !cur_dropped) begin
      void'(exp_i.pop_back());
      cur_dropped = 1;
    end
    @(posedge clk); #1;
    i_flush = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_i.size() != 0 || exp_d.size() != 0) && n < 200) begin
      @(negedge clk); #3; n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
    @(negedge clk); #3;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"},   {31'b0, m_req}, 32'd0);
    chk({tag, "_m_we"},    {31'b0, m_we}, 32'd0);
    chk({tag, "_m_addr"},  m_addr, 32'd0);
    chk({tag, "_m_wdata"}, m_wdata, 32'd0);
    chk({tag, "_m_size"},  {29'b0, m_size}, 32'd0);
    chk({tag, "_i_gnt"},   {31'b0, i_gnt}, 32'd0);
    chk({tag, "_d_gnt"},   {31'b0, d_gnt}, 32'd0);
    chk({tag, "_i_rvalid"}, {31'b0, i_rvalid}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'b0, d_rvalid}, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  chk_next;
    rst = 1; i_req = 0; i_addr = 0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0;
    ref_mem[32'h40] = 32'h0050_0093;
    slv_mem[32'h40] = 32'h0050_0093;
    slave_en = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #3;
    chk_all_zero("reset");

    // Single fetch, best-case latency
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h40;
    @(negedge clk); #3;
    chk("t1_i_gnt", {31'b0, i_gnt}, 32'd1);
    chk("t1_d_gnt", {31'b0, d_gnt}, 32'd0);
    @(posedge clk); #1;
    i_req = 0;
    @(negedge clk); #3;
    chk("t1_m_req", {31'b0, m_req}, 32'd1);
    chk("t1_m_addr", m_addr, 32'h40);
    chk("t1_d_rvalid_a", {31'b0, d_rvalid}, 32'd0);
    @(negedge clk); #3;
    chk("t1_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("t1_i_rdata", i_rdata, 32'h0050_0093);
    chk("t1_d_rvalid_b", {31'b0, d_rvalid}, 32'd0);
    wait_idle();

    // Store with three stall cycles, then load back
    rd_cfg = 3;
    cnt = n_drv;
    data(1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010);
    wait_idle();
    chk("t2_store_ack", 32'(n_drv), 32'(cnt + 1));
    chk("t2_store_rdata", last_d_rdata, 32'd0);
    rd_cfg = 0;
    data(1'b0, 32'h100, 32'd0, 3'b010);
    wait_idle();
    chk("t2_load_data", last_d_rdata, 32'hDEAD_BEEF);

    // Contention with both requests held high
    glog = ""; cnt = 0; chk_next = 0;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h100; d_size = 3'b010;
    while (glog.len() < 10 && cnt < 300) begin
      @(negedge clk); #3; cnt++;
      if (chk_next) chk("t3_starve_clear", {28'b0, dut.starve_q}, 32'd0);
      chk_next = i_gnt;
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    @(negedge clk); #3;
    if (chk_next) chk("t3_starve_clear", {28'b0, dut.starve_q}, 32'd0);
    total++;
    if (glog != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL t3_grant_order: got %s want DDDDIDDDDI", glog);
    end
    wait_idle();

    // Flush while the fetch is waiting for its response
    rv_cfg = 4;
    cnt = n_irv;
    fetch(32'h40);
    @(posedge clk); #1;
    pulse_flush();
    wait_idle();
    chk("t4_flush_wait_suppressed", 32'(n_irv), 32'(cnt));
    rv_cfg = 1;
    fetch(32'h40);
    wait_idle();
    chk("t4_next_fetch_delivered", 32'(n_irv), 32'(cnt + 1));
    chk("t4_next_fetch_data", last_i_rdata, 32'h0050_0093);

    // Flush in the same cycle as the fetch grant
    cnt = n_irv;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h44; i_flush = 1;
    @(negedge clk); #3;
    chk("t5_i_gnt", {31'b0, i_gnt}, 32'd1);
    @(posedge clk); #1;
    i_req = 0; i_flush = 0;
    wait_idle();
    chk("t5_flush_gnt_suppressed", 32'(n_irv), 32'(cnt));
    fetch(32'h40);
    wait_idle();
    chk("t5_next_fetch_delivered", 32'(n_irv), 32'(cnt + 1));

    // Reset while a load is in ISSUE, then a stray memory response
    slave_en = 0;
    cnt = n_drv;
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h100; d_size = 3'b010;
    @(negedge clk); #3;
    chk("t6_d_gnt", {31'b0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    d_req = 0;
    @(negedge clk); #3;
    chk("t6_m_req", {31'b0, m_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_d.delete(); req_q.delete(); busy = 0;
    @(negedge clk); #3;
    chk_all_zero("t6_after_rst");
    @(posedge clk); #1;
    m_rvalid = 1; m_rdata = 32'h1234_5678;
    @(negedge clk); #3;
    chk("t6_late_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("t6_late_d_rdata", d_rdata, 32'd0);
    chk("t6_late_m_req", {31'b0, m_req}, 32'd0);
    @(posedge clk); #1;
    m_rvalid = 0; m_rdata = 0;
    slave_en = 1;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h40;
    @(negedge clk); #3;
    chk("t6_idle_gnt", {31'b0, i_gnt}, 32'd1);
    @(posedge clk); #1;
    i_req = 0;
    wait_idle();
    chk("t6_no_d_rvalid", 32'(n_drv), 32'(cnt));

    // Randomised latencies over 1000 mixed transactions
    rand_mode = 1;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          fetch(32'h200 + 32'($urandom_range(0, 15) * 4));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            pulse_flush();
          end
        end
      end
      begin
        for (int k = 0; k < 600; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          data(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 15) * 4),
               $urandom, 3'($urandom_range(0, 2)));
        end
      end
    join
    wait_idle();
    chk("t7_exp_i_drained", 32'(exp_i.size()), 32'd0);
    chk("t7_exp_d_drained", 32'(exp_d.size()), 32'd0);
    chk("t7_req_q_drained", 32'(req_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
